// File: rtl/geri_yazma_pkg.sv
// Shared widths, destination-field position and queue entry type for the write-back unit.
package geri_yazma_pkg;

  localparam int VERI_W    = 8;
  localparam int ADRES_W   = 3;
  localparam int HEDEF_MSB = 5;
  localparam int HEDEF_LSB = 3;

  typedef struct packed {
    logic [ADRES_W-1:0] adres;
    logic [VERI_W-1:0]  veri;
  } kuyruk_girdisi_t;

endpackage

// File: rtl/yazma_kuyrugu.sv
// In-order circular write queue; exposes all entries plus read pointer and count for the bypass search.
module yazma_kuyrugu
  import geri_yazma_pkg::*;
#(
  parameter int DERINLIK = 4,
  localparam int PTR_W = $clog2(DERINLIK),
  localparam int SAY_W = PTR_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            yaz,
  input  logic            oku,
  input  kuyruk_girdisi_t yeni,
  output kuyruk_girdisi_t girdiler [DERINLIK],
  output kuyruk_girdisi_t bas,
  output logic [PTR_W-1:0] oku_ptr,
  output logic [SAY_W-1:0] sayac,
  output logic            dolu,
  output logic            bos
);

  logic [PTR_W-1:0] yaz_ptr;
  logic             ekle;
  logic             cikar;

  assign dolu  = (sayac == SAY_W'(DERINLIK));
  assign bos   = (sayac == '0);
  assign ekle  = yaz && !dolu;
  assign cikar = oku && !bos;
  assign bas   = girdiler[oku_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      girdiler <= '{default: '0};
      yaz_ptr  <= '0;
      oku_ptr  <= '0;
      sayac    <= '0;
    end else begin
      if (ekle) begin
        girdiler[yaz_ptr] <= yeni;
        yaz_ptr           <= yaz_ptr + PTR_W'(1);
      end
      if (cikar) begin
        oku_ptr <= oku_ptr + PTR_W'(1);
      end
      case ({ekle, cikar})
        2'b10:   sayac <= sayac + SAY_W'(1);
        2'b01:   sayac <= sayac - SAY_W'(1);
        default: sayac <= sayac;
      endcase
    end
  end

endmodule

// File: rtl/geri_yazma_birimi.sv
// Write-back unit: queues ALU results, arbitrates the register-file write port with memory loads.
// GERI_YAZMA_BYPASS_EN: read ports forward the youngest matching queued result.
module geri_yazma_birimi #(
  parameter int VERI_W           = 8,
  parameter int YAZMAC_SAYISI    = 8,
  parameter int KUYRUK_DERINLIGI = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              veriyi_yaz_i,
  input  logic [VERI_W-1:0] sonuc_i,
  input  logic [15:0]       emir_i,
  input  logic              bellek_yaz_i,
  input  logic [2:0]        bellek_adres_i,
  input  logic [VERI_W-1:0] bellek_veri_i,
  input  logic [2:0]        oku1_adres_i,
  input  logic [2:0]        oku2_adres_i,
  output logic [VERI_W-1:0] oku1_veri_o,
  output logic [VERI_W-1:0] oku2_veri_o,
  output logic              hazir_o,
  output logic              kuyruk_bos_o,
  output logic              tasma_o
);
  import geri_yazma_pkg::*;

  localparam int PTR_W = $clog2(KUYRUK_DERINLIGI);

  logic [VERI_W-1:0] yazmaclar [YAZMAC_SAYISI];
  kuyruk_girdisi_t   yeni;
  kuyruk_girdisi_t   bas;
  kuyruk_girdisi_t   girdiler [KUYRUK_DERINLIGI];
  logic [PTR_W-1:0]  oku_ptr;
  logic [PTR_W:0]    sayac;
  logic              dolu;
  logic              bos;
  logic              bosalt;
  logic              tasma;

  assign yeni   = '{adres: emir_i[HEDEF_MSB:HEDEF_LSB], veri: sonuc_i};
  // A memory load owns the write port; the queue only drains on load-free cycles.
  assign bosalt = !bellek_yaz_i && !bos;

  yazma_kuyrugu #(
    .DERINLIK(KUYRUK_DERINLIGI)
  ) u_kuyruk (
    .clk     (clk),
    .rst     (rst),
    .yaz     (veriyi_yaz_i),
    .oku     (bosalt),
    .yeni    (yeni),
    .girdiler(girdiler),
    .bas     (bas),
    .oku_ptr (oku_ptr),
    .sayac   (sayac),
    .dolu    (dolu),
    .bos     (bos)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      yazmaclar <= '{default: '0};
    end else if (bellek_yaz_i) begin
      yazmaclar[bellek_adres_i] <= bellek_veri_i;
    end else if (!bos) begin
      yazmaclar[bas.adres] <= bas.veri;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tasma <= 1'b0;
    end else if (veriyi_yaz_i && dolu) begin
      tasma <= 1'b1;
    end
  end

  function automatic logic [VERI_W-1:0] oku(input logic [2:0] a);
    logic [VERI_W-1:0] v;
    v = yazmaclar[a];
`ifdef GERI_YAZMA_BYPASS_EN
    // Walk oldest to youngest so the youngest live match is the one left in v.
    for (int unsigned i = 0; i < KUYRUK_DERINLIGI; i++) begin
      logic [PTR_W-1:0] idx;
      idx = oku_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < sayac) && (girdiler[idx].adres == a)) begin
        v = girdiler[idx].veri;
      end
    end
`endif
    return v;
  endfunction

`ifndef GERI_YAZMA_BYPASS_EN
  logic kuyruk_unused;
  always_comb begin
    kuyruk_unused = ^{oku_ptr, sayac};
    for (int unsigned i = 0; i < KUYRUK_DERINLIGI; i++) begin
      kuyruk_unused = kuyruk_unused ^ (^girdiler[i]);
    end
  end
`endif

  logic emir_unused;
  assign emir_unused = ^{emir_i[15:HEDEF_MSB+1], emir_i[HEDEF_LSB-1:0]};

  always_comb begin
    oku1_veri_o = oku(oku1_adres_i);
    oku2_veri_o = oku(oku2_adres_i);
  end

  assign hazir_o      = !dolu;
  assign kuyruk_bos_o = bos;
  assign tasma_o      = tasma;

endmodule

// File: tb/tb_geri_yazma_birimi.sv
// Self-checking bench for geri_yazma_birimi: queue-level reference model plus directed scenarios.
module tb_geri_yazma_birimi;

`ifdef GERI_YAZMA_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        veriyi_yaz_i = 1'b0;
  logic [7:0]  sonuc_i = '0;
  logic [15:0] emir_i = '0;
  logic        bellek_yaz_i = 1'b0;
  logic [2:0]  bellek_adres_i = '0;
  logic [7:0]  bellek_veri_i = '0;
  logic [2:0]  oku1_adres_i = '0;
  logic [2:0]  oku2_adres_i = '0;
  logic [7:0]  oku1_veri_o;
  logic [7:0]  oku2_veri_o;
  logic        hazir_o;
  logic        kuyruk_bos_o;
  logic        tasma_o;

  int toplam = 0;
  int hata   = 0;

  geri_yazma_birimi #(
    .VERI_W(8),
    .YAZMAC_SAYISI(8),
    .KUYRUK_DERINLIGI(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .veriyi_yaz_i  (veriyi_yaz_i),
    .sonuc_i       (sonuc_i),
    .emir_i        (emir_i),
    .bellek_yaz_i  (bellek_yaz_i),
    .bellek_adres_i(bellek_adres_i),
    .bellek_veri_i (bellek_veri_i),
    .oku1_adres_i  (oku1_adres_i),
    .oku2_adres_i  (oku2_adres_i),
    .oku1_veri_o   (oku1_veri_o),
    .oku2_veri_o   (oku2_veri_o),
    .hazir_o       (hazir_o),
    .kuyruk_bos_o  (kuyruk_bos_o),
    .tasma_o       (tasma_o)
  );

  always #5 clk = ~clk;

  // Reference: a register array, a FIFO of {addr,data}, and a sticky drop flag.
  logic [7:0]  m_reg [8] = '{default: 8'h00};
  logic [10:0] m_q [$];
  logic        m_tasma = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    logic [10:0] e;
    logic        dolu;
    if (!rst) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      m_q.delete();
      m_tasma = 1'b0;
    end else begin
      dolu = (m_q.size() == 4);
      if (bellek_yaz_i) begin
        m_reg[bellek_adres_i] = bellek_veri_i;
      end else if (m_q.size() != 0) begin
        e = m_q.pop_front();
        m_reg[e[10:8]] = e[7:0];
      end
      if (veriyi_yaz_i) begin
        if (dolu) m_tasma = 1'b1;
        else m_q.push_back({emir_i[5:3], sonuc_i});
      end
    end
  end

  function automatic logic [7:0] m_oku(input logic [2:0] a);
    if (BYPASS) begin
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (m_q[i][10:8] == a) return m_q[i][7:0];
      end
    end
    return m_reg[a];
  endfunction

  task automatic kontrol(input string ad, input logic [7:0] gercek, input logic [7:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: actual %02h required %02h (t=%0t)", ad, gercek, beklenen, $time);
    end
  endtask

  always @(negedge clk) begin : karsilastir
    kontrol("m_oku1", oku1_veri_o, m_oku(oku1_adres_i));
    kontrol("m_oku2", oku2_veri_o, m_oku(oku2_adres_i));
    kontrol("m_hazir", 8'(hazir_o), 8'(m_q.size() < 4));
    kontrol("m_bos", 8'(kuyruk_bos_o), 8'(m_q.size() == 0));
    kontrol("m_tasma", 8'(tasma_o), 8'(m_tasma));
  end

  task automatic saat();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #1 rst = 1'b0;
    saat();
    saat();
    rst = 1'b1;
    saat();

    // Reset state on every register, both ports
    for (int a = 0; a < 8; a++) begin
      oku1_adres_i = 3'(a);
      oku2_adres_i = 3'(7 - a);
      saat();
      kontrol("reset_oku1", oku1_veri_o, 8'h00);
      kontrol("reset_oku2", oku2_veri_o, 8'h00);
    end
    kontrol("reset_hazir", 8'(hazir_o), 8'h01);
    kontrol("reset_bos", 8'(kuyruk_bos_o), 8'h01);

    // 0x5A to r3
    oku1_adres_i = 3'd3;
    veriyi_yaz_i = 1'b1; sonuc_i = 8'h5A; emir_i = 16'h0018;
    saat();
    veriyi_yaz_i = 1'b0;
    kontrol("r3_accept_edge", oku1_veri_o, BYPASS ? 8'h5A : 8'h00);
    kontrol("r3_bos_after_accept", 8'(kuyruk_bos_o), 8'h00);
    saat();
    kontrol("r3_retired", oku1_veri_o, 8'h5A);
    kontrol("r3_bos_after_retire", 8'(kuyruk_bos_o), 8'h01);
    kontrol("model_r3", m_reg[3], 8'h5A);

    // Five requests under a continuous load: four fit, fifth overflows
    bellek_yaz_i = 1'b1; bellek_adres_i = 3'd7; bellek_veri_i = 8'hEE;
    veriyi_yaz_i = 1'b1; emir_i = 16'h0020;
    for (int k = 0; k < 5; k++) begin
      sonuc_i = 8'(8'h31 + k);
      saat();
      if (k == 3) kontrol("full_hazir", 8'(hazir_o), 8'h00);
      if (k == 3) kontrol("full_tasma_not_yet", 8'(tasma_o), 8'h00);
      if (k == 4) kontrol("drop_tasma", 8'(tasma_o), 8'h01);
    end
    veriyi_yaz_i = 1'b0; bellek_yaz_i = 1'b0;
    oku1_adres_i = 3'd4; oku2_adres_i = 3'd7;
    repeat (4) saat();
    kontrol("drain_r4", oku1_veri_o, 8'h34);
    kontrol("load_r7", oku2_veri_o, 8'hEE);
    kontrol("tasma_sticky", 8'(tasma_o), 8'h01);
    kontrol("drain_bos", 8'(kuyruk_bos_o), 8'h01);

    // r2 twice while queued: youngest wins
    bellek_yaz_i = 1'b1;
    veriyi_yaz_i = 1'b1; emir_i = 16'h0010; sonuc_i = 8'h11;
    saat();
    sonuc_i = 8'h22;
    saat();
    veriyi_yaz_i = 1'b0;
    oku2_adres_i = 3'd2;
    kontrol("r2_youngest", oku2_veri_o, BYPASS ? 8'h22 : 8'h00);
    bellek_yaz_i = 1'b0;
    saat();
    saat();
    kontrol("r2_rf", oku2_veri_o, 8'h22);
    kontrol("model_r2", m_reg[2], 8'h22);

    // Load to r5 while r1 is pending
    bellek_yaz_i = 1'b1; bellek_adres_i = 3'd7;
    veriyi_yaz_i = 1'b1; emir_i = 16'h0008; sonuc_i = 8'h10;
    saat();
    veriyi_yaz_i = 1'b0;
    bellek_adres_i = 3'd5; bellek_veri_i = 8'h77;
    oku1_adres_i = 3'd5; oku2_adres_i = 3'd1;
    saat();
    kontrol("load_r5", oku1_veri_o, 8'h77);
    kontrol("r1_pending", oku2_veri_o, BYPASS ? 8'h10 : 8'h00);
    kontrol("load_keeps_queue", 8'(kuyruk_bos_o), 8'h00);
    bellek_yaz_i = 1'b0;
    saat();
    kontrol("r1_retired", oku2_veri_o, 8'h10);
    kontrol("r1_bos", 8'(kuyruk_bos_o), 8'h01);

    // Reset mid-drain with three entries queued
    bellek_yaz_i = 1'b1; bellek_adres_i = 3'd7; bellek_veri_i = 8'hEE;
    veriyi_yaz_i = 1'b1; emir_i = 16'h0030;
    for (int k = 0; k < 3; k++) begin
      sonuc_i = 8'(8'h61 + k);
      saat();
    end
    veriyi_yaz_i = 1'b0; bellek_yaz_i = 1'b0;
    oku1_adres_i = 3'd6; oku2_adres_i = 3'd7;
    saat();
    kontrol("r6_mid_drain", oku1_veri_o, BYPASS ? 8'h63 : 8'h61);
    rst = 1'b0;
    #1;
    kontrol("rst_bos", 8'(kuyruk_bos_o), 8'h01);
    kontrol("rst_hazir", 8'(hazir_o), 8'h01);
    kontrol("rst_tasma", 8'(tasma_o), 8'h00);
    kontrol("rst_r6", oku1_veri_o, 8'h00);
    kontrol("rst_r7", oku2_veri_o, 8'h00);
    saat();
    rst = 1'b1;
    repeat (3) saat();
    kontrol("post_rst_r6", oku1_veri_o, 8'h00);
    kontrol("post_rst_bos", 8'(kuyruk_bos_o), 8'h01);

    // Mixed traffic pattern checked by the model every cycle
    for (int i = 0; i < 24; i++) begin
      veriyi_yaz_i   = (i % 3) != 2;
      sonuc_i        = 8'(i * 7 + 1);
      emir_i         = 16'((i % 8) << 3);
      bellek_yaz_i   = (i % 5) == 0;
      bellek_adres_i = 3'((i + 3) % 8);
      bellek_veri_i  = 8'(8'h80 | i);
      oku1_adres_i   = 3'(i % 8);
      oku2_adres_i   = 3'((i + 4) % 8);
      saat();
    end
    veriyi_yaz_i = 1'b0; bellek_yaz_i = 1'b0;
    repeat (6) saat();
    kontrol("final_bos", 8'(kuyruk_bos_o), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", toplam, hata);
    $finish;
  end

endmodule

// File: doc/geri_yazma_birimi.md
# geri_yazma_birimi

Write-back unit for the processor datapath: the receiving end of the arithmetic unit's `veriyi_yaz`/`sonuc` write-request interface. It captures each ALU result with its destination register taken from the instruction word, buffers it in a small in-order queue, and retires it into an 8×8 register file. The register file's single write port is shared with memory-load write-back, which has priority. The block exposes two read ports that forward still-queued results.

## Interface
Parameters:
- `VERI_W`, 8, data width of results and registers
- `YAZMAC_SAYISI`, 8, number of registers (address width = 3)
- `KUYRUK_DERINLIGI`, 4, write-queue depth (power of two)

Ports:
- `clk`  in  1  clock; one clock; reset is asynchronous and active-low
- `rst`  in  1  asynchronous active-low reset (0 = reset)
- `veriyi_yaz_i`  in  1  ALU write request, one result per asserted cycle
- `sonuc_i`  in  VERI_W  ALU result
- `emir_i`  in  16  instruction word; destination register = `emir_i[5:3]`
- `bellek_yaz_i`  in  1  memory-load write request, bypasses the queue
- `bellek_adres_i`  in  3  load destination register
- `bellek_veri_i`  in  VERI_W  load data
- `oku1_adres_i`, `oku2_adres_i`  in  3  read addresses
- `oku1_veri_o`, `oku2_veri_o`  out  VERI_W  read data (combinational)
- `hazir_o`  out  1  queue not full; ALU request will be accepted
- `kuyruk_bos_o`  out  1  queue empty
- `tasma_o`  out  1  sticky overflow flag

## Operation
- Accept: `veriyi_yaz_i && hazir_o` at a rising edge enqueues {`emir_i[5:3]`, `sonuc_i`} at the write pointer.
- Drop: `veriyi_yaz_i && !hazir_o` discards the request and sets `tasma_o`. The flag is cleared only by reset.
- Write port arbitration, one write per cycle:
  - `bellek_yaz_i` = 1: the memory load is written and the queue does not drain.
  - Otherwise, a non-empty queue retires its oldest entry.
- Enqueue and drain in the same cycle are both performed; the count is unchanged.
- `hazir_o` is computed from the registered count only. A full queue rejects a request even while it drains that cycle.
- Ordering:
  - Queue entries retire strictly in order.
  - A load to a register with a pending queue entry is overwritten when that entry retires. Ordering between loads and ALU results is the issuing controller's responsibility.
- Reads are combinational from current state; same-cycle incoming writes are not visible. Source priority:
  1. Youngest matching queue entry (when forwarding is enabled).
  2. Otherwise, the register file.
- Pointers are `$clog2(KUYRUK_DERINLIGI)` bits and wrap modulo depth. The count is one bit wider (0..KUYRUK_DERINLIGI).
- Reset, asynchronous: all registers 0, pointers 0, count 0, `tasma_o` 0, `hazir_o` 1, `kuyruk_bos_o` 1. Queued entries are lost. Read outputs are 0 while reset is held.

## Timing
- Accept at edge N:
  - The result is readable through the bypass from edge N onward.
  - With no load competing, it is in the register file after edge N+1.
- Each cycle of `bellek_yaz_i` delays the drain by one cycle.
- `hazir_o`, `kuyruk_bos_o` and `tasma_o` are registered-state outputs and update on the edge after the event.
- Reset release takes effect at the first rising edge with `rst` = 1.

## Configuration
- `GERI_YAZMA_BYPASS_EN` defined: read ports forward from the queue (youngest match wins).
- Undefined: read ports return register-file contents only. A result becomes readable after it retires, i.e. edge N+1 at the earliest. The queue search logic is removed.

## Structure
- Package `geri_yazma_pkg` holds:
  - `VERI_W`
  - `ADRES_W` = 3
  - destination field positions `HEDEF_MSB` = 5, `HEDEF_LSB` = 3
  - typedef `kuyruk_girdisi_t` {adres, veri}
- Sub-module `yazma_kuyrugu`: circular buffer with pointers, count, full/empty flags, and an exposed entry array for the bypass search. Arbitration, the register file and the read muxes stay in the top level.

## Test plan
- Reset, then read all 8 registers on both ports -> all 0; `hazir_o` = 1, `kuyruk_bos_o` = 1.
- Enqueue 0x5A to r3 (`emir_i` = 16'h0018) -> `oku1_veri_o` = 0x5A from the next edge (bypass). With the macro off, it reads 0x00 until one edge later.
- Five back-to-back requests while `bellek_yaz_i` = 1 -> first four accepted, `hazir_o` = 0; fifth dropped, `tasma_o` = 1 and stays 1 after the queue drains.
- r2 queued as 0x11 then 0x22 -> reading r2 returns 0x22. After both entries drain, the register file holds 0x22.
- Load 0x77 to r5 while the queue holds r1 = 0x10 -> r5 = 0x77 that edge, queue count unchanged; r1 is written the following cycle.
- Drive `rst` = 0 mid-drain with 3 entries queued -> queue empties immediately, registers 0, `tasma_o` 0; no further writes after release.
